// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: default core geometry, retire state encoding
// and the warp-ID type used by the writeback/retire logic.
package gpu_pkg;

    localparam int GPU_NUM_WARPS    = 8;
    localparam int GPU_LANES        = 32;
    localparam int GPU_MAX_INFLIGHT = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } retire_state_e;

    typedef logic [$clog2(GPU_NUM_WARPS)-1:0] warp_id_t;

endpackage

// File: rtl/wb_retire_if.sv
// Writeback/retire bundle between the SIMT pipeline, the retire tracker and
// the performance counter. The tracker takes the slave view.
interface wb_retire_if
    import gpu_pkg::*;
#(
    parameter int NUM_WARPS    = GPU_NUM_WARPS,
    parameter int LANES        = GPU_LANES,
    parameter int MAX_INFLIGHT = GPU_MAX_INFLIGHT
);

    logic                              issue_v;
    logic                              wb_v;
    logic [$clog2(NUM_WARPS)-1:0]      wb_warp;
    logic [LANES-1:0]                  wb_mask;
    logic                              wb_is_halt;
    logic                              W_v;
    logic [15:0]                       numIns;
    logic                              isHalt;
    logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight;
    logic                              err;

    modport master (
        output issue_v, wb_v, wb_warp, wb_mask, wb_is_halt,
        input  W_v, numIns, isHalt, inflight, err
    );

    modport slave (
        input  issue_v, wb_v, wb_warp, wb_mask, wb_is_halt,
        output W_v, numIns, isHalt, inflight, err
    );

endinterface

// File: rtl/wb_retire_lane_popcount.sv
// Combinational population count of an active-lane mask, zero-extended to 16 bits.
module lane_popcount #(
    parameter int LANES = 32
) (
    input  logic [LANES-1:0] mask,
    output logic [15:0]      count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < LANES; i++) begin
            count = count + 16'(mask[i]);
        end
    end

endmodule

// File: rtl/wb_retire.sv
// Writeback retire tracker: registered retire pulses, in-flight count, per-warp
// halts and sticky program-halt. WB_LANE_COUNT_EN selects lane (thread) counting.
module wb_retire
    import gpu_pkg::*;
#(
    parameter int NUM_WARPS    = GPU_NUM_WARPS,
    parameter int MAX_INFLIGHT = GPU_MAX_INFLIGHT
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_retire_if.slave bus
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int WW = $clog2(NUM_WARPS);
    localparam logic [IW-1:0] INF_MAX = IW'(MAX_INFLIGHT);

    retire_state_e        state_q, state_d;
    logic [NUM_WARPS-1:0] halted_q, halted_d;
    logic [IW-1:0]        inflight_q, inflight_d;
    logic                 err_q, err_d;
    logic                 w_v_q, w_v_d;
    logic [15:0]          num_ins_q, num_ins_d;
    logic                 is_halt_q, is_halt_d;
    logic                 warp_ok;
    logic [15:0]          lane_cnt;

`ifdef WB_LANE_COUNT_EN
    lane_popcount #(
        .LANES($bits(bus.wb_mask))
    ) u_popcount (
        .mask  (bus.wb_mask),
        .count (lane_cnt)
    );
`else
    assign lane_cnt = 16'd1;
`endif

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        w_v_d      = bus.wb_v;
        num_ins_d  = num_ins_q;
        is_halt_d  = is_halt_q;
        warp_ok    = 1'b0;

        if (bus.wb_v) begin
            num_ins_d = lane_cnt;
        end

        if (bus.issue_v && !bus.wb_v) begin
            if (inflight_q == INF_MAX) err_d = 1'b1;
            else                       inflight_d = inflight_q + 1'b1;
        end else if (bus.wb_v && !bus.issue_v) begin
            if (inflight_q == '0) err_d = 1'b1;
            else                  inflight_d = inflight_q - 1'b1;
        end

        // Out-of-range warp IDs match no entry: they retire but never set a halt bit.
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (bus.wb_v && bus.wb_warp == WW'(i)) begin
                warp_ok = 1'b1;
                if (halted_q[i])    err_d       = 1'b1;
                if (bus.wb_is_halt) halted_d[i] = 1'b1;
            end
        end
        if (bus.wb_v && !warp_ok) err_d = 1'b1;
        if (bus.issue_v && state_q != RUN) err_d = 1'b1;

        // DRAIN is entered as the last halt lands so DONE follows one cycle after drain.
        case (state_q)
            RUN:     if (&halted_d) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase

        if (state_d == DONE) is_halt_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            halted_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            w_v_q      <= 1'b0;
            num_ins_q  <= '0;
            is_halt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            w_v_q      <= w_v_d;
            num_ins_q  <= num_ins_d;
            is_halt_q  <= is_halt_d;
        end
    end

    assign bus.W_v      = w_v_q;
    assign bus.numIns   = num_ins_q;
    assign bus.isHalt   = is_halt_q;
    assign bus.inflight = inflight_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_wb_retire.sv
// Scoreboard bench for wb_retire: retire pulses checked by a negedge monitor,
// bookkeeping outputs checked at fixed points of directed sequences.
module tb_wb_retire;
    import gpu_pkg::*;

    localparam int NW = GPU_NUM_WARPS;
    localparam int LN = GPU_LANES;
    localparam int MI = GPU_MAX_INFLIGHT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];

    wb_retire_if #(.NUM_WARPS(NW), .LANES(LN), .MAX_INFLIGHT(MI)) bus ();

    wb_retire #(
        .NUM_WARPS    (NW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sel(input int hand);
`ifdef WB_LANE_COUNT_EN
        return 16'(hand);
`else
        return 16'd1;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iss, input logic wb, input warp_id_t warp,
                                 input logic [LN-1:0] mask, input logic halt, input int cnt);
        bus.issue_v    = iss;
        bus.wb_v       = wb;
        bus.wb_warp    = warp;
        bus.wb_mask    = mask;
        bus.wb_is_halt = halt;
        if (wb) exp_q.push_back(sel(cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 0);
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        checkOutput("rst_w_v", 32'(bus.W_v), 0);
        checkOutput("rst_numIns", 32'(bus.numIns), 0);
        checkOutput("rst_isHalt", 32'(bus.isHalt), 0);
        checkOutput("rst_inflight", 32'(bus.inflight), 0);
        checkOutput("rst_err", 32'(bus.err), 0);
        bus.issue_v = 1'b0;
        bus.wb_v    = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.W_v) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL w_v_unexpected got numIns=%0d want no pulse", bus.numIns);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.numIns !== e) begin
                    bad++;
                    $display("[TB] FAIL numIns got=%0d want=%0d", bus.numIns, e);
                end
            end
        end
    end

    initial begin
        bus.issue_v    = 1'b0;
        bus.wb_v       = 1'b1;
        bus.wb_warp    = '0;
        bus.wb_mask    = '1;
        bus.wb_is_halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("init_w_v", 32'(bus.W_v), 0);
        checkOutput("init_numIns", 32'(bus.numIns), 0);
        checkOutput("init_isHalt", 32'(bus.isHalt), 0);
        checkOutput("init_inflight", 32'(bus.inflight), 0);
        checkOutput("init_err", 32'(bus.err), 0);
        bus.wb_v = 1'b0;
        rst_n    = 1'b1;
        idle();
        checkOutput("post_rst_w_v0", 32'(bus.W_v), 0);
        idle();
        checkOutput("post_rst_w_v1", 32'(bus.W_v), 0);

        $display("[TB] retire counts");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        checkOutput("rc_inflight4", 32'(bus.inflight), 4);
        applyStimulus(1'b0, 1'b1, warp_id_t'(0), 32'hFFFF_FFFF, 1'b0, 32);
        applyStimulus(1'b0, 1'b1, warp_id_t'(1), 32'h0000_0005, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, warp_id_t'(2), 32'h0000_0000, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(3), 32'h8000_0001, 1'b0, 2);
        idle();
        checkOutput("rc_idle_w_v", 32'(bus.W_v), 0);
        checkOutput("rc_hold_numIns", 32'(bus.numIns), 32'(sel(2)));
        checkOutput("rc_inflight0", 32'(bus.inflight), 0);
        checkOutput("rc_err", 32'(bus.err), 0);

        $display("[TB] inflight");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        checkOutput("if_after_issue", 32'(bus.inflight), 3);
        applyStimulus(1'b1, 1'b1, warp_id_t'(0), 32'h1, 1'b0, 1);
        checkOutput("if_issue_and_wb", 32'(bus.inflight), 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, warp_id_t'(1), 32'h3, 1'b0, 2);
        checkOutput("if_drained", 32'(bus.inflight), 0);
        checkOutput("if_err_clean", 32'(bus.err), 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(2), 32'h1, 1'b0, 1);
        checkOutput("if_underflow_err", 32'(bus.err), 1);
        checkOutput("if_underflow_hold", 32'(bus.inflight), 0);
        idle();

        $display("[TB] halt drain");
        resetPulse();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        for (int w = 0; w < NW; w++) applyStimulus(1'b0, 1'b1, warp_id_t'(w), 32'h1, 1'b1, 1);
        checkOutput("hd_inflight2", 32'(bus.inflight), 2);
        checkOutput("hd_not_halted", 32'(bus.isHalt), 0);
        checkOutput("hd_err_clean", 32'(bus.err), 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(0), 32'hF, 1'b0, 4);
        checkOutput("hd_mid_isHalt", 32'(bus.isHalt), 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(0), 32'hF, 1'b0, 4);
        checkOutput("hd_t1_isHalt", 32'(bus.isHalt), 0);
        checkOutput("hd_t1_w_v", 32'(bus.W_v), 1);
        checkOutput("hd_t1_inflight", 32'(bus.inflight), 0);
        idle();
        checkOutput("hd_t2_isHalt", 32'(bus.isHalt), 1);
        checkOutput("hd_wb_halted_err", 32'(bus.err), 1);
        idle();
        checkOutput("hd_sticky_isHalt", 32'(bus.isHalt), 1);

        $display("[TB] double halt");
        resetPulse();
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(3), 32'hF0F0_0000, 1'b1, 8);
        checkOutput("dh_first_err", 32'(bus.err), 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(3), 32'hF0F0_0000, 1'b1, 8);
        checkOutput("dh_second_err", 32'(bus.err), 1);
        checkOutput("dh_second_w_v", 32'(bus.W_v), 1);
        checkOutput("dh_inflight", 32'(bus.inflight), 0);
        idle();

        $display("[TB] reset mid-drain");
        resetPulse();
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        for (int w = 0; w < NW - 1; w++) applyStimulus(1'b0, 1'b1, warp_id_t'(w), 32'h3, 1'b1, 2);
        checkOutput("md_inflight4", 32'(bus.inflight), 4);
        checkOutput("md_err_clean", 32'(bus.err), 0);
        applyStimulus(1'b1, 1'b1, warp_id_t'(NW - 1), 32'h7, 1'b0, 3);
        checkOutput("md_pending_w_v", 32'(bus.W_v), 1);
        resetPulse();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, warp_id_t'(NW - 1), 32'h1, 1'b1, 1);
        repeat (3) idle();
        checkOutput("md_halted_cleared", 32'(bus.isHalt), 0);
        checkOutput("md_err_after", 32'(bus.err), 0);

        $display("[TB] inflight ceiling");
        resetPulse();
        for (int i = 0; i < MI + 1; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 0);
        checkOutput("ceil_inflight", 32'(bus.inflight), MI);
        checkOutput("ceil_err", 32'(bus.err), 1);

        idle();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
